// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared constants, state type and lane mapping for ram_loader
// Optional RAM_LOADER_BIG_ENDIAN_EN reverses the byte-lane order within a word.
package ram_loader_pkg;

  localparam logic [7:0] CMD_WR_ST_DEFAULT = 8'h2a;
  localparam logic [7:0] CMD_WR_SP_DEFAULT = 8'h2b;
  localparam int         LANES             = 4;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  function automatic logic [3:0] lane_to_be(input logic [1:0] lane);
`ifdef RAM_LOADER_BIG_ENDIAN_EN
    return 4'b1000 >> lane;
`else
    return 4'b0001 << lane;
`endif
  endfunction

endpackage

// File: rtl/ram_loader_addr_gen.sv
// rtl/ram_loader_addr_gen.sv - lane/word counters producing registered write address and byte enable
// Lane order follows RAM_LOADER_BIG_ENDIAN_EN via ram_loader_pkg::lane_to_be.
module ram_loader_addr_gen
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [3:0]            byte_en
);

  logic [1:0]            lane_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  // clear only rewinds the counters; the outputs keep the last write's values
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q  <= 2'd0;
      addr_q  <= '0;
      addr    <= '0;
      byte_en <= lane_to_be(2'd0);
    end else if (clear) begin
      lane_q <= 2'd0;
      addr_q <= '0;
    end else if (advance) begin
      addr    <= addr_q;
      byte_en <= lane_to_be(lane_q);
      lane_q  <= lane_q + 2'd1;
      if (lane_q == 2'(LANES - 1)) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - command-framed byte stream to byte-lane RAM write adapter
// Build option RAM_LOADER_BIG_ENDIAN_EN selects big-endian lane order.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 13,
  parameter logic [7:0] CMD_WR_ST  = CMD_WR_ST_DEFAULT,
  parameter logic [7:0] CMD_WR_SP  = CMD_WR_SP_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dc_i,
  input  logic                  byte_rdy_i,
  input  logic [7:0]            byte_data_i,
  output logic                  wr_en_o,
  output logic                  wr_done_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [3:0]            wr_byte_en_o
);

  state_t state;
  logic   is_cmd;
  logic   is_start;
  logic   is_stop;
  logic   is_data;

  assign is_cmd   = byte_rdy_i & ~dc_i;
  assign is_start = is_cmd && (byte_data_i == CMD_WR_ST);
  assign is_stop  = is_cmd && (byte_data_i == CMD_WR_SP);
  assign is_data  = byte_rdy_i & dc_i & (state == LOAD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      wr_en_o <= 1'b0;
    end else begin
      wr_en_o <= is_data;
      if (is_start) begin
        state <= LOAD;
      end else if (is_stop && state == LOAD) begin
        state <= IDLE;
      end
    end
  end

  assign wr_done_o = (state == IDLE);

  ram_loader_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (is_start),
    .advance(is_data),
    .addr   (wr_addr_o),
    .byte_en(wr_byte_en_o)
  );

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - self-checking bench for ram_loader (honours RAM_LOADER_BIG_ENDIAN_EN)
module tb_ram_loader;

  localparam int AW = 13;

`ifdef RAM_LOADER_BIG_ENDIAN_EN
  localparam logic [3:0] L0 = 4'b1000, L1 = 4'b0100, L2 = 4'b0010, L3 = 4'b0001;
`else
  localparam logic [3:0] L0 = 4'b0001, L1 = 4'b0010, L2 = 4'b0100, L3 = 4'b1000;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dc = 1'b0;
  logic          byte_rdy = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          wr_en;
  logic          wr_done;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_byte_en;

  int tests = 0;
  int fails = 0;

  // reference model: session flag and count of bytes written since the last start
  bit            m_sess;
  int            m_cnt;
  logic          m_en;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_be;

  ram_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .dc_i        (dc),
    .byte_rdy_i  (byte_rdy),
    .byte_data_i (byte_data),
    .wr_en_o     (wr_en),
    .wr_done_o   (wr_done),
    .wr_addr_o   (wr_addr),
    .wr_byte_en_o(wr_byte_en)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lane_be(input int idx);
    case (idx)
      0: return L0;
      1: return L1;
      2: return L2;
      default: return L3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic rdy, input logic d, input logic [7:0] b);
    m_en = 1'b0;
    if (r) begin
      m_sess = 0; m_cnt = 0; m_addr = '0; m_be = L0;
    end else if (rdy) begin
      if (!d) begin
        if (b == 8'h2a) begin
          m_sess = 1; m_cnt = 0;
        end else if (b == 8'h2b) begin
          m_sess = 0;
        end
      end else if (m_sess) begin
        m_en   = 1'b1;
        m_addr = AW'((m_cnt / 4) % (1 << AW));
        m_be   = lane_be(m_cnt % 4);
        m_cnt++;
      end
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic d, input logic [7:0] b);
    @(negedge clk);
    rst = r; byte_rdy = rdy; dc = d; byte_data = b;
    @(posedge clk);
    #1;
    model(r, rdy, d, b);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".wr_en"},   32'(wr_en),      32'(m_en));
    check({tag, ".wr_done"}, 32'(wr_done),    32'(!m_sess));
    check({tag, ".wr_addr"}, 32'(wr_addr),    32'(m_addr));
    check({tag, ".byte_en"}, 32'(wr_byte_en), 32'(m_be));
  endtask

  typedef struct {
    logic          r, rdy, d;
    logic [7:0]    b;
    logic          en, done;
    logic [AW-1:0] addr;
    logic [3:0]    be;
  } vec_t;

  vec_t vt[18];

  initial begin
    vt[0]  = '{1, 0, 0, 8'h00, 0, 1, 0, L0};  // reset
    vt[1]  = '{0, 0, 0, 8'h00, 0, 1, 0, L0};
    vt[2]  = '{0, 1, 1, 8'h11, 0, 1, 0, L0};  // data while idle
    vt[3]  = '{0, 1, 0, 8'h2b, 0, 1, 0, L0};  // stop while idle
    vt[4]  = '{0, 1, 0, 8'h2a, 0, 0, 0, L0};  // start
    vt[5]  = '{0, 1, 1, 8'h00, 1, 0, 0, L0};
    vt[6]  = '{0, 0, 1, 8'h00, 0, 0, 0, L0};  // hold
    vt[7]  = '{0, 1, 1, 8'h01, 1, 0, 0, L1};
    vt[8]  = '{0, 1, 0, 8'h55, 0, 0, 0, L1};  // unknown command
    vt[9]  = '{0, 1, 1, 8'h02, 1, 0, 0, L2};
    vt[10] = '{0, 1, 1, 8'h03, 1, 0, 0, L3};
    vt[11] = '{0, 1, 1, 8'h04, 1, 0, 1, L0};
    vt[12] = '{0, 1, 0, 8'h2a, 0, 0, 1, L0};  // restart holds outputs
    vt[13] = '{0, 1, 1, 8'h05, 1, 0, 0, L0};
    vt[14] = '{0, 1, 0, 8'h2b, 0, 1, 0, L0};  // stop
    vt[15] = '{0, 1, 1, 8'h06, 0, 1, 0, L0};
    vt[16] = '{0, 1, 0, 8'h2a, 0, 0, 0, L0};
    vt[17] = '{1, 1, 1, 8'h07, 0, 1, 0, L0};  // reset beats strobe

    m_sess = 0; m_cnt = 0; m_en = 0; m_addr = '0; m_be = L0;

    for (int i = 0; i < 18; i++) begin
      step(vt[i].r, vt[i].rdy, vt[i].d, vt[i].b);
      check($sformatf("vec%0d.wr_en", i),   32'(wr_en),      32'(vt[i].en));
      check($sformatf("vec%0d.wr_done", i), 32'(wr_done),    32'(vt[i].done));
      check($sformatf("vec%0d.wr_addr", i), 32'(wr_addr),    32'(vt[i].addr));
      check($sformatf("vec%0d.byte_en", i), 32'(wr_byte_en), 32'(vt[i].be));
    end

    // idle after reset: nothing moves
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 8'h00);
      check_model("idle");
    end

    // full 64-byte load; model expects addr i/4 with lanes cycling
    step(0, 1, 0, 8'h2a);
    check("start.done_fall", 32'(wr_done), 32'(0));
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 1, 8'(i));
      check_model("load64");
    end
    check("load64.last_addr", 32'(wr_addr), 32'(15));
    check("load64.last_be", 32'(wr_byte_en), 32'(L3));
    step(0, 1, 0, 8'h2b);
    check("stop.done_rise", 32'(wr_done), 32'(1));

    // restart mid-word lands on address 0, first lane
    step(0, 1, 0, 8'h2a);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 8'(i));
    step(0, 1, 0, 8'h2a);
    step(0, 1, 1, 8'hee);
    check("restart.addr", 32'(wr_addr), 32'(0));
    check("restart.be", 32'(wr_byte_en), 32'(L0));
    check("restart.en", 32'(wr_en), 32'(1));

    // reset mid-session abandons the load
    step(0, 1, 0, 8'h2a);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 8'(i));
    step(1, 0, 0, 8'h00);
    check_model("midrst");
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 8'(i));
      check_model("postrst");
    end

    // address wrap across the whole word space
    step(0, 1, 0, 8'h2a);
    for (int i = 0; i < (4 << AW) + 6; i++) begin
      step(0, 1, 1, 8'(i));
      if (i >= (4 << AW) - 6) check_model("wrap");
    end
    check("wrap.addr", 32'(wr_addr), 32'(1));
    step(0, 1, 0, 8'h2b);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic          r, rdy, d;
      logic [7:0]    b;
      int            sel;
      r   = ($urandom_range(0, 149) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 4) != 0);
      sel = $urandom_range(0, 5);
      b   = (sel == 0) ? 8'h2a : (sel == 1) ? 8'h2b : (sel == 2) ? 8'h55 : 8'($urandom);
      step(r, rdy, d, b);
      check_model("rand");
    end

    @(negedge clk);
    byte_rdy = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
